imem_load_arb: RTL and testbench

Arbiter and load sequencer for the CPU's 4096×32 instruction RAM. It shares the single RAM port between the CPU fetch path and a host load port. While loading, it holds the CPU in reset and streams host words into consecutive RAM addresses. When the load ends it releases the CPU so execution restarts from PC 0.

---
 rtl/imem_load_arb.sv | 204 ++++++++++++++++++++
 tb/tb_imem_load_arb.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_load_arb.sv
// imem_load_arb: shares the single instruction-RAM port between the CPU fetch
// path and a host load port. During a load the CPU is held in reset, host
// beats are written to consecutive addresses, and the CPU is released to
// restart from PC 0 once the load completes or is aborted.
module imem_load_arb #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int DRAIN_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_pc,
  output logic              cpu_rst_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_last,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_cnt,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  // Last drain-counter value before the load window opens.
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYC - 1);
  // Saturation ceiling for the beat counter (one full RAM worth of beats).
  localparam logic [ADDR_W:0] WORD_MAX = {1'b1, {ADDR_W{1'b0}}};

  // Saturating increment so word_cnt sticks at the RAM depth.
  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
    if (v == WORD_MAX) begin
      return v;
    end else begin
      return v + {{ADDR_W{1'b0}}, 1'b1};
    end
  endfunction

  state_t              state_r;
  state_t              next_state_s;
  logic                next_err_s;
  logic                accept_s;
  logic                start_s;
  logic [3:0]          drain_cnt_r;
  logic [ADDR_W-1:0]   addr_cnt_r;
  logic [ADDR_W-1:0]   wr_addr_r;
  logic [ADDR_W:0]     word_cnt_r;
  logic [DATA_W-1:0]   checksum_r;
  logic [DATA_W-1:0]   mem_wdata_r;
  logic                mem_we_r;
  logic                cpu_rst_n_r;
  logic                wr_ready_r;
  logic                load_done_r;
  logic                load_err_r;

  // wr_ready_r is only ever high while in LOAD, so this is the handshake.
  assign accept_s = wr_ready_r & wr_valid;
  assign start_s  = (state_r == ST_RUN) & load_req;

  // Next-state and next-error decision for the load sequencer.
  always_comb begin
    next_state_s = state_r;
    next_err_s   = load_err_r;
    case (state_r)
      ST_RUN: begin
        if (load_req) begin
          next_state_s = ST_DRAIN;
          next_err_s   = 1'b0;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!load_req) begin
          next_state_s = ST_RELEASE;
          next_err_s   = 1'b1;
        end else if (drain_cnt_r == DRAIN_LAST) begin
          next_state_s = ST_LOAD;
        end else begin
          next_state_s = ST_DRAIN;
        end
      end
      ST_LOAD: begin
        // A final beat wins over a simultaneous drop of load_req.
        if (accept_s && wr_last) begin
          next_state_s = ST_FLUSH;
        end else if (!accept_s && !load_req) begin
          next_state_s = ST_FLUSH;
          next_err_s   = 1'b1;
        end else begin
          next_state_s = ST_LOAD;
        end
      end
      ST_FLUSH: begin
        next_state_s = ST_RELEASE;
      end
      ST_RELEASE: begin
        next_state_s = ST_RUN;
      end
      default: begin
        next_state_s = ST_RUN;
      end
    endcase
  end

  // State register plus the control outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_RUN;
      load_err_r  <= 1'b0;
      cpu_rst_n_r <= 1'b0;
      wr_ready_r  <= 1'b0;
      load_done_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      load_err_r  <= next_err_s;
      cpu_rst_n_r <= (next_state_s == ST_RUN);
      wr_ready_r  <= (next_state_s == ST_LOAD);
      load_done_r <= (next_state_s == ST_RELEASE) & ~next_err_s;
    end
  end

  // Drain counter: counts cycles spent in DRAIN before opening the load window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drain_cnt_r <= 4'd0;
    end else if (start_s) begin
      drain_cnt_r <= 4'd0;
    end else if (state_r == ST_DRAIN) begin
      drain_cnt_r <= drain_cnt_r + 4'd1;
    end else begin
      drain_cnt_r <= drain_cnt_r;
    end
  end

  // Write address counter, beat counter and running checksum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_cnt_r <= {ADDR_W{1'b0}};
      word_cnt_r <= {(ADDR_W+1){1'b0}};
      checksum_r <= {DATA_W{1'b0}};
    end else if (start_s) begin
      addr_cnt_r <= load_base;
      word_cnt_r <= {(ADDR_W+1){1'b0}};
      checksum_r <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      addr_cnt_r <= addr_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      word_cnt_r <= sat_inc(word_cnt_r);
      checksum_r <= checksum_r + wr_data;
    end else begin
      addr_cnt_r <= addr_cnt_r;
      word_cnt_r <= word_cnt_r;
      checksum_r <= checksum_r;
    end
  end

  // Registered RAM write port: one-cycle latency from beat accept to write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_we_r    <= 1'b0;
      mem_wdata_r <= {DATA_W{1'b0}};
      wr_addr_r   <= {ADDR_W{1'b0}};
    end else if (accept_s) begin
      mem_we_r    <= 1'b1;
      mem_wdata_r <= wr_data;
      wr_addr_r   <= addr_cnt_r;
    end else begin
      mem_we_r    <= 1'b0;
      mem_wdata_r <= mem_wdata_r;
      wr_addr_r   <= wr_addr_r;
    end
  end

  // RAM address mux: the CPU owns the port in RUN, the write path otherwise.
  always_comb begin
    if (state_r == ST_RUN) begin
      mem_addr = cpu_pc;
    end else begin
      mem_addr = wr_addr_r;
    end
  end

  assign cpu_rst_n = cpu_rst_n_r;
  assign mem_we    = mem_we_r;
  assign mem_wdata = mem_wdata_r;
  assign wr_ready  = wr_ready_r;
  assign load_done = load_done_r;
  assign load_err  = load_err_r;
  assign word_cnt  = word_cnt_r;
  assign checksum  = checksum_r;

endmodule

// File: tb/tb_imem_load_arb.sv
// Randomized scoreboard bench for imem_load_arb: stimulus tasks push expected
// RAM writes and load_done pulses into queues; a negedge monitor pops and
// compares whenever the DUT presents a write or a done pulse.
module tb_imem_load_arb;
  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 32;
  localparam int DRAIN_CYC = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] cpu_pc;
  logic              cpu_rst_n;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              load_req;
  logic [ADDR_W-1:0] load_base;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              wr_last;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   word_cnt;
  logic [DATA_W-1:0] checksum;

  int checks = 0;
  int errors = 0;
  wr_t         exp_wr_q[$];
  int          exp_done_q[$];
  logic [DATA_W-1:0] stim_q[$];

  imem_load_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_pc(cpu_pc), .cpu_rst_n(cpu_rst_n),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .load_req(load_req), .load_base(load_base), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
    .load_done(load_done), .load_err(load_err), .word_cnt(word_cnt),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every RAM write and done pulse must match the scoreboard head.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_t e;
      if (exp_wr_q.size() == 0) begin
        chk("unexpected_write", {20'd0, mem_addr, mem_wdata}, 64'd0);
      end else begin
        e = exp_wr_q.pop_front();
        chk("write_addr", mem_addr, e.addr);
        chk("write_data", mem_wdata, e.data);
      end
      chk("write_cpu_held", cpu_rst_n, 1'b0);
    end
    if (load_done === 1'b1) begin
      if (exp_done_q.size() == 0) begin
        chk("unexpected_done", 1'b1, 1'b0);
      end else begin
        void'(exp_done_q.pop_front());
        chk("done_pulse", load_done, 1'b1);
      end
    end
  end

  // CPU owns the port: mem_addr follows cpu_pc, no writes, no ready.
  task automatic run_idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      cpu_pc   = ADDR_W'($urandom);
      wr_valid = 1'($urandom);
      wr_data  = $urandom;
      #1;
      chk("run_addr", mem_addr, cpu_pc);
      chk("run_we", mem_we, 1'b0);
      chk("run_ready", wr_ready, 1'b0);
      step();
    end
    wr_valid = 1'b0;
  endtask

  // One load: abort_after < 0 means normal completion with n beats.
  task automatic run_load(input logic [ADDR_W-1:0] base, input int n, input int abort_after,
                          input bit bubbles, input bit drop_with_last);
    int                k;
    int                nb;
    bit                abort;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   exp_cnt;
    logic [DATA_W-1:0] exp_sum;
    logic [DATA_W-1:0] d;
    wr_t               e;
    abort     = (abort_after >= 0);
    nb        = abort ? abort_after : n;
    load_base = base;
    load_req  = 1'b1;
    wr_valid  = 1'b0;
    wr_last   = 1'b0;
    step();
    chk("cpu_held_after_req", cpu_rst_n, 1'b0);
    load_base = ADDR_W'($urandom);
    k = 1;
    while (wr_ready !== 1'b1 && k < 20) begin
      chk("ready_low_in_drain", wr_ready, 1'b0);
      step();
      k++;
    end
    chk("drain_latency", k, DRAIN_CYC + 1);
    if (k >= 20) begin
      load_req = 1'b0;
      return;
    end
    addr    = base;
    exp_cnt = '0;
    exp_sum = '0;
    for (int i = 0; i < nb; i++) begin
      if (bubbles && i > 0) begin
        wr_valid = 1'b0;
        step();
        chk("bubble_no_we", mem_we, 1'b0);
        chk("ready_in_load", wr_ready, 1'b1);
        chk("cpu_held_in_load", cpu_rst_n, 1'b0);
      end
      d = (stim_q.size() > 0) ? stim_q.pop_front() : $urandom;
      wr_valid = 1'b1;
      wr_data  = d;
      wr_last  = (!abort && i == n - 1);
      if (wr_last && drop_with_last) load_req = 1'b0;
      e.addr = addr;
      e.data = d;
      exp_wr_q.push_back(e);
      addr    = addr + 1'b1;
      exp_cnt = (exp_cnt == 13'h1000) ? exp_cnt : exp_cnt + 1'b1;
      exp_sum = exp_sum + d;
      if (wr_last) exp_done_q.push_back(1);
      step();
      chk("we_after_accept", mem_we, 1'b1);
    end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    load_req = 1'b0;
    if (!abort) begin
      chk("flush_ready", wr_ready, 1'b0);
      chk("word_cnt", word_cnt, exp_cnt);
      chk("checksum", checksum, exp_sum);
      chk("flush_cpu_held", cpu_rst_n, 1'b0);
      step();
      chk("release_done", load_done, 1'b1);
      chk("release_ready", wr_ready, 1'b0);
      chk("release_err", load_err, 1'b0);
      chk("release_cpu_held", cpu_rst_n, 1'b0);
      step();
      chk("cpu_released", cpu_rst_n, 1'b1);
      chk("run_no_we", mem_we, 1'b0);
    end else begin
      step();
      chk("abort_err", load_err, 1'b1);
      chk("abort_word_cnt", word_cnt, exp_cnt);
      chk("abort_checksum", checksum, exp_sum);
      chk("abort_no_we", mem_we, 1'b0);
      step();
      chk("abort_no_done", load_done, 1'b0);
      step();
      chk("abort_cpu_released", cpu_rst_n, 1'b1);
      chk("abort_err_sticky", load_err, 1'b1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    cpu_pc    = '0;
    load_req  = 1'b0;
    load_base = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    wr_last   = 1'b0;
    step();
    step();
    chk("rst_cpu_rst_n", cpu_rst_n, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_load_done", load_done, 1'b0);
    chk("rst_load_err", load_err, 1'b0);
    chk("rst_word_cnt", word_cnt, 13'd0);
    chk("rst_checksum", checksum, 32'd0);
    rst_n = 1'b1;
    step();
    chk("cpu_out_of_reset", cpu_rst_n, 1'b1);
    run_idle(8);

    // Basic program load at address 0.
    stim_q = '{32'h00000013, 32'h00100093, 32'h00208113, 32'h0000006F};
    run_load(12'h000, 4, -1, 1'b0, 1'b0);
    run_idle(3);
    // Address wrap across the top of the RAM.
    run_load(12'hFFE, 3, -1, 1'b0, 1'b0);
    run_idle(2);
    // Bubbles between beats.
    run_load(12'h123, 3, -1, 1'b1, 1'b0);
    run_idle(2);
    // Abort after two beats.
    run_load(12'h040, 4, 2, 1'b0, 1'b0);
    run_idle(2);
    // Final beat in the same cycle load_req falls: normal completion.
    run_load(12'h080, 3, -1, 1'b0, 1'b1);
    run_idle(2);

    // Abort while still draining.
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    step();
    chk("drain_abort_err", load_err, 1'b1);
    chk("drain_abort_cpu_held", cpu_rst_n, 1'b0);
    step();
    chk("drain_abort_released", cpu_rst_n, 1'b1);
    run_idle(2);

    // Randomized loads.
    for (int r = 0; r < 12; r++) begin
      int n;
      int ab;
      n  = $urandom_range(1, 8);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      run_load(ADDR_W'($urandom), n, ab, 1'($urandom), 1'($urandom));
      run_idle($urandom_range(1, 3));
    end

    // Reset in the middle of a load.
    load_base = 12'h200;
    load_req  = 1'b1;
    step();
    for (int k = 0; k < 20 && wr_ready !== 1'b1; k++) step();
    chk("midrst_ready", wr_ready, 1'b1);
    begin
      wr_t e;
      e.addr = 12'h200;
      e.data = 32'hCAFE0001;
      exp_wr_q.push_back(e);
    end
    wr_valid = 1'b1;
    wr_data  = 32'hCAFE0001;
    step();
    rst_n   = 1'b0;
    wr_data = 32'hDEAD0002;
    step();
    chk("midrst_we", mem_we, 1'b0);
    chk("midrst_cpu_rst_n", cpu_rst_n, 1'b0);
    chk("midrst_ready_low", wr_ready, 1'b0);
    chk("midrst_err", load_err, 1'b0);
    chk("midrst_word_cnt", word_cnt, 13'd0);
    chk("midrst_checksum", checksum, 32'd0);
    chk("midrst_wdata", mem_wdata, 32'd0);
    chk("midrst_addr_run", mem_addr, cpu_pc);
    wr_valid = 1'b0;
    load_req = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("midrst_released", cpu_rst_n, 1'b1);
    run_idle(4);

    chk("writes_drained", exp_wr_q.size(), 0);
    chk("dones_drained", exp_done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
